// File: rtl/vote_result_tx.sv
// ---------------------------------------------------------------------------
// vote_result_tx
//   Transmit-only serial result reporter for the voting machine.
//   A results_valid pulse taken in IDLE snapshots the five candidate tallies
//   and sends one 7-byte frame on tx:
//     HEADER, A, B, C, D, E, CHK  with CHK = (A+B+C+D+E) mod 256.
//   Each byte is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1),
//   and every bit lasts CLKS_PER_BIT clock cycles.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   results_valid  1-cycle request to send the current tallies
//   vote_count_A..E  candidate tallies, CNT_W bits each
//   tx             serial line, idle high
//   busy           high while a frame is in flight
//   done           1-cycle pulse in the cycle after the last stop bit
// ---------------------------------------------------------------------------
module vote_result_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          CNT_W        = 4,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             results_valid,
  input  logic [CNT_W-1:0] vote_count_A,
  input  logic [CNT_W-1:0] vote_count_B,
  input  logic [CNT_W-1:0] vote_count_C,
  input  logic [CNT_W-1:0] vote_count_D,
  input  logic [CNT_W-1:0] vote_count_E,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  state_t          state;
  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_idx;
  logic [2:0]      byte_idx;
  logic [4:0][7:0] snap;
  logic [7:0]      chk;

  logic [7:0] ext_a, ext_b, ext_c, ext_d, ext_e;
  logic [7:0] sum_next;
  logic [7:0] cur_byte;
  logic       bit_end;

  // Tallies are zero-extended; the 8-bit sum wraps naturally, giving mod 256.
  assign ext_a    = 8'(vote_count_A);
  assign ext_b    = 8'(vote_count_B);
  assign ext_c    = 8'(vote_count_C);
  assign ext_d    = 8'(vote_count_D);
  assign ext_e    = 8'(vote_count_E);
  assign sum_next = ext_a + ext_b + ext_c + ext_d + ext_e;

  assign bit_end = (clk_cnt == BIT_LAST);

  // Byte currently being serialised, selected from the frozen snapshot so
  // input changes after acceptance never reach the line.
  always_comb begin
    cur_byte = HEADER;
    case (byte_idx)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = snap[0];
      3'd2:    cur_byte = snap[1];
      3'd3:    cur_byte = snap[2];
      3'd4:    cur_byte = snap[3];
      3'd5:    cur_byte = snap[4];
      3'd6:    cur_byte = chk;
      default: cur_byte = HEADER;
    endcase
  end

  // Frame sequencer. tx is loaded one cycle ahead of each bit period so the
  // line value always comes straight from a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      snap     <= '0;
      chk      <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (results_valid) begin
            snap     <= {ext_e, ext_d, ext_c, ext_b, ext_a};
            chk      <= sum_next;
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx      <= cur_byte[0];
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (byte_idx == 3'd6) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              tx    <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              state    <= START;
              tx       <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_result_tx.sv
// ---------------------------------------------------------------------------
// tb_vote_result_tx
//   Self-checking bench for vote_result_tx. Expected frames come from a
//   byte-level model (header, tallies, modulo-256 sum); the captured line is
//   decoded by sampling the middle of each bit period.
// ---------------------------------------------------------------------------
module tb_vote_result_tx;

  localparam int CPB       = 16;
  localparam int CNT_W     = 4;
  localparam int FRAME_CYC = 70 * CPB;
  localparam int HIST_LEN  = FRAME_CYC + 80;

  logic             clk;
  logic             reset;
  logic             results_valid;
  logic [CNT_W-1:0] vote_count_A, vote_count_B, vote_count_C, vote_count_D, vote_count_E;
  logic             tx, busy, done;

  int checks   = 0;
  int failures = 0;

  logic       hist [HIST_LEN];
  logic [7:0] exp_frame [7];

  vote_result_tx #(.CLKS_PER_BIT(CPB), .CNT_W(CNT_W), .HEADER(8'hA5)) dut (
    .clk           (clk),
    .reset         (reset),
    .results_valid (results_valid),
    .vote_count_A  (vote_count_A),
    .vote_count_B  (vote_count_B),
    .vote_count_C  (vote_count_C),
    .vote_count_D  (vote_count_D),
    .vote_count_E  (vote_count_E),
    .tx            (tx),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference frame: header, zero-extended tallies, then their sum mod 256.
  task automatic model_frame(input int a, input int b, input int c, input int d, input int e);
    exp_frame[0] = 8'hA5;
    exp_frame[1] = 8'(a);
    exp_frame[2] = 8'(b);
    exp_frame[3] = 8'(c);
    exp_frame[4] = 8'(d);
    exp_frame[5] = 8'(e);
    exp_frame[6] = 8'((a + b + c + d + e) % 256);
  endtask

  task automatic set_counts(input int a, input int b, input int c, input int d, input int e);
    vote_count_A = CNT_W'(a);
    vote_count_B = CNT_W'(b);
    vote_count_C = CNT_W'(c);
    vote_count_D = CNT_W'(d);
    vote_count_E = CNT_W'(e);
  endtask

  // Called at a falling edge; returns at the falling edge just after acceptance.
  task automatic start_frame();
    results_valid = 1'b1;
    @(negedge clk);
    results_valid = 1'b0;
  endtask

  // Records tx per cycle (cycle 0 = first cycle of the HEADER start bit) until
  // done is seen or the budget runs out, injecting the requested disturbances.
  task automatic capture(input int change_cycle, input int extra1, input int extra2,
                         input bit revalid_at_done,
                         output int done_cycle, output int busy_cycles);
    done_cycle  = -1;
    busy_cycles = 0;
    for (int c = 0; c < HIST_LEN; c++) begin
      hist[c] = tx;
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) begin
        done_cycle = c;
        break;
      end
      results_valid = (c == extra1) || (c == extra2);
      if (c == change_cycle) set_counts(9, 9, 9, 9, 9);
      @(negedge clk);
    end
    results_valid = 1'b0;
    if (revalid_at_done && done_cycle >= 0) begin
      results_valid = 1'b1;
      @(negedge clk);
      results_valid = 1'b0;
    end
  endtask

  task automatic verify_frame(input string tag, input int done_cycle, input int busy_cycles);
    logic [7:0] got;
    bit framing_ok;
    check({tag, " done_cycle"}, 32'(done_cycle), 32'(FRAME_CYC));
    check({tag, " busy_cycles"}, 32'(busy_cycles), 32'(FRAME_CYC));
    if (done_cycle == FRAME_CYC) begin
      framing_ok = 1'b1;
      for (int j = 0; j < 7; j++) begin
        if (hist[(j * 10) * CPB + CPB / 2] !== 1'b0) framing_ok = 1'b0;
        if (hist[(j * 10 + 9) * CPB + CPB / 2] !== 1'b1) framing_ok = 1'b0;
        for (int b = 0; b < 8; b++) got[b] = hist[(j * 10 + 1 + b) * CPB + CPB / 2];
        check($sformatf("%s byte%0d", tag, j), 32'(got), 32'(exp_frame[j]));
      end
      check({tag, " framing"}, 32'(framing_ok), 32'd1);
    end
  endtask

  initial begin
    int dc, bc;
    bit quiet_ok;
    int ra, rb, rc, rd, re;

    $display("[TB] start");
    reset         = 1'b1;
    results_valid = 1'b0;
    set_counts(0, 0, 0, 0, 0);

    // Reset and idle: outputs stay at rest with no stimulus.
    repeat (3) @(negedge clk);
    check("reset tx", 32'(tx), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    reset = 1'b0;
    quiet_ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) quiet_ok = 1'b0;
    end
    check("idle quiet", 32'(quiet_ok), 32'd1);

    // Basic frame.
    set_counts(2, 1, 1, 1, 0);
    model_frame(2, 1, 1, 1, 0);
    start_frame();
    check("first cycle tx", 32'(tx), 32'd0);
    check("first cycle busy", 32'(busy), 32'd1);
    capture(-1, -1, -1, 1'b0, dc, bc);
    verify_frame("basic", dc, bc);
    @(negedge clk);
    check("basic done width", 32'(done), 32'd0);
    check("basic idle tx", 32'(tx), 32'd1);

    // Tallies change during byte 2: frame is unaffected.
    set_counts(2, 1, 1, 1, 0);
    model_frame(2, 1, 1, 1, 0);
    start_frame();
    capture(2 * 10 * CPB, -1, -1, 1'b0, dc, bc);
    verify_frame("late_change", dc, bc);
    @(negedge clk);

    // Extra requests while busy are ignored.
    set_counts(4, 3, 2, 1, 0);
    model_frame(4, 3, 2, 1, 0);
    start_frame();
    capture(-1, 100, 600, 1'b0, dc, bc);
    verify_frame("extra_pulses", dc, bc);
    quiet_ok = 1'b1;
    repeat (CPB * 12) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || tx !== 1'b1) quiet_ok = 1'b0;
    end
    check("extra_pulses no second frame", 32'(quiet_ok), 32'd1);

    // Reset during byte 3.
    set_counts(5, 5, 5, 5, 5);
    start_frame();
    repeat (3 * 10 * CPB + 40) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset tx", 32'(tx), 32'd1);
    check("midreset busy", 32'(busy), 32'd0);
    quiet_ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) quiet_ok = 1'b0;
    end
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) quiet_ok = 1'b0;
    end
    check("midreset no done", 32'(quiet_ok), 32'd1);
    set_counts(3, 7, 12, 0, 5);
    model_frame(3, 7, 12, 0, 5);
    start_frame();
    capture(-1, -1, -1, 1'b0, dc, bc);
    verify_frame("after_reset", dc, bc);
    @(negedge clk);

    // All tallies at maximum, request re-issued in the done cycle.
    set_counts(15, 15, 15, 15, 15);
    model_frame(15, 15, 15, 15, 15);
    start_frame();
    capture(-1, -1, -1, 1'b1, dc, bc);
    verify_frame("max_first", dc, bc);
    check("b2b start tx", 32'(tx), 32'd0);
    check("b2b start busy", 32'(busy), 32'd1);
    capture(-1, -1, -1, 1'b0, dc, bc);
    verify_frame("max_second", dc, bc);
    @(negedge clk);

    // Randomised tallies.
    for (int k = 0; k < 3; k++) begin
      ra = int'($urandom_range(0, 15));
      rb = int'($urandom_range(0, 15));
      rc = int'($urandom_range(0, 15));
      rd = int'($urandom_range(0, 15));
      re = int'($urandom_range(0, 15));
      set_counts(ra, rb, rc, rd, re);
      model_frame(ra, rb, rc, rd, re);
      repeat (int'($urandom_range(1, 20))) @(negedge clk);
      start_frame();
      capture(int'($urandom_range(1, 1000)), -1, -1, 1'b0, dc, bc);
      verify_frame($sformatf("random%0d", k), dc, bc);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
